decode_stage: RTL and testbench

//  RISC-V RV32I decode stage, directly upstream of the register file.

---
 rtl/decode_stage.sv | 81 ++++++++
 tb/tb_decode_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file addressing, immediate generation and write-back bypass
module decode_stage #(
   parameter int XLEN = 32,
   parameter int REG_AW = 5
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              if_valid,
   input  logic [XLEN-1:0]   if_instr,
   input  logic [XLEN-1:0]   if_pc,
   output logic              id_ready,
   input  logic              flush,
   output logic [REG_AW-1:0] read_reg1,
   output logic [REG_AW-1:0] read_reg2,
   input  logic [XLEN-1:0]   rf_data1,
   input  logic [XLEN-1:0]   rf_data2,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_write_reg,
   input  logic [XLEN-1:0]   wb_write_data,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic [6:0]        ex_opcode,
   output logic [2:0]        ex_funct3,
   output logic              ex_funct7b5,
   output logic              ex_illegal
);
   logic [XLEN-1:0] instr, pc, byp1_d, byp2_d, imm;
   logic byp1_v, byp2_v, accept, legal;
   assign id_ready = flush | ~ex_valid | ex_ready;
   assign accept = if_valid & id_ready & ~flush;
   assign read_reg1 = accept ? if_instr[19:15] : instr[19:15];
   assign read_reg2 = accept ? if_instr[24:20] : instr[24:20];
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         instr <= '0;
         pc <= '0;
         ex_valid <= 1'b0;
         byp1_v <= 1'b0;
         byp2_v <= 1'b0;
         byp1_d <= '0;
         byp2_d <= '0;
      end else begin
         if (accept) begin
            instr <= if_instr;
            pc <= if_pc;
            ex_valid <= 1'b1;
         end else if (ex_ready | flush)
            ex_valid <= 1'b0;
         byp1_v <= wb_regwrite & (wb_write_reg != '0) & (wb_write_reg == read_reg1);
         byp2_v <= wb_regwrite & (wb_write_reg != '0) & (wb_write_reg == read_reg2);
         byp1_d <= wb_write_data;
         byp2_d <= wb_write_data;
      end
   always_comb begin
      imm = '0;
      legal = 1'b1;
      case (instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm = {{20{instr[31]}}, instr[31:20]};
         7'b0100011: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         7'b1100011: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         7'b0110111, 7'b0010111: imm = {instr[31:12], 12'b0};
         7'b1101111: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         7'b0110011, 7'b0001111: imm = '0;
         default: legal = 1'b0;
      endcase
   end
   assign ex_pc = pc;
   assign ex_imm = imm;
   assign ex_rs1_data = byp1_v ? byp1_d : rf_data1;
   assign ex_rs2_data = byp2_v ? byp2_d : rf_data2;
   assign ex_rd = instr[11:7];
   assign ex_opcode = instr[6:0];
   assign ex_funct3 = instr[14:12];
   assign ex_funct7b5 = instr[30];
   assign ex_illegal = ex_valid & ~legal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector and sequence checks of decode_stage against a registered-read register file model
module tb_decode_stage;
   logic        CLK = 1'b0, RESET_N = 1'b0;
   logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0, wb_regwrite = 1'b0;
   logic [31:0] if_instr = '0, if_pc = '0, wb_write_data = '0, rf_data1 = '0, rf_data2 = '0;
   logic [4:0]  wb_write_reg = '0;
   logic        id_ready, ex_valid, ex_funct7b5, ex_illegal;
   logic [4:0]  read_reg1, read_reg2, ex_rd;
   logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] regs [32];
   int checks = 0, errors = 0;
   decode_stage dut (
      .CLK(CLK), .RESET_N(RESET_N), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_regwrite(wb_regwrite),
      .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) begin
      rf_data1 <= regs[read_reg1];
      rf_data2 <= regs[read_reg2];
      if (wb_regwrite && wb_write_reg != 5'd0) regs[wb_write_reg] <= wb_write_data;
   end
   typedef struct {
      logic [31:0] instr, imm, rs1;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, ill;
   } vec_t;
   vec_t v [13];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h", n, a, e);
      end
   endtask
   task automatic edge_();
      @(posedge CLK);
      #1;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      v[0]  = '{32'h00500093, 32'h00000005, 32'h00000000, 5'd1,  7'h13, 3'd0, 1'b0, 1'b0};
      v[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 32'h00000000, 5'd29, 7'h63, 3'd0, 1'b1, 1'b0};
      v[2]  = '{32'h123452B7, 32'h12345000, 32'h10000008, 5'd5,  7'h37, 3'd5, 1'b0, 1'b0};
      v[3]  = '{32'h0020A423, 32'h00000008, 32'h10000001, 5'd8,  7'h23, 3'd2, 1'b0, 1'b0};
      v[4]  = '{32'hFE20AE23, 32'hFFFFFFFC, 32'h10000001, 5'd28, 7'h23, 3'd2, 1'b1, 1'b0};
      v[5]  = '{32'hFFFFF06F, 32'hFFFFFFFE, 32'h1000001F, 5'd0,  7'h6F, 3'd7, 1'b1, 1'b0};
      v[6]  = '{32'h80000397, 32'h80000000, 32'h00000000, 5'd7,  7'h17, 3'd0, 1'b0, 1'b0};
      v[7]  = '{32'h002081B3, 32'h00000000, 32'h10000001, 5'd3,  7'h33, 3'd0, 1'b0, 1'b0};
      v[8]  = '{32'h402081B3, 32'h00000000, 32'h10000001, 5'd3,  7'h33, 3'd0, 1'b1, 1'b0};
      v[9]  = '{32'h0000007F, 32'h00000000, 32'h00000000, 5'd0,  7'h7F, 3'd0, 1'b0, 1'b1};
      v[10] = '{32'hFFF12203, 32'hFFFFFFFF, 32'h10000002, 5'd4,  7'h03, 3'd2, 1'b1, 1'b0};
      v[11] = '{32'h0FF0000F, 32'h00000000, 32'h00000000, 5'd0,  7'h0F, 3'd0, 1'b0, 1'b0};
      v[12] = '{32'h000080E7, 32'h00000000, 32'h10000001, 5'd1,  7'h67, 3'd0, 1'b0, 1'b0};
      #12;
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_pc", ex_pc, 32'd0);
      chk("rst_imm", ex_imm, 32'd0);
      chk("rst_illegal", {31'd0, ex_illegal}, 32'd0);
      chk("rst_rs1", ex_rs1_data, 32'd0);
      chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
      @(negedge CLK);
      RESET_N = 1'b1;
      ex_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if_valid = 1'b1;
         if_instr = v[i].instr;
         if_pc = 32'h100 + 32'(i) * 4;
         edge_();
         chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, 32'd1);
         chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(i) * 4);
         chk($sformatf("v%0d_imm", i), ex_imm, v[i].imm);
         chk($sformatf("v%0d_rs1", i), ex_rs1_data, v[i].rs1);
         chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, v[i].rd});
         chk($sformatf("v%0d_op", i), {25'd0, ex_opcode}, {25'd0, v[i].op});
         chk($sformatf("v%0d_f3", i), {29'd0, ex_funct3}, {29'd0, v[i].f3});
         chk($sformatf("v%0d_f7b5", i), {31'd0, ex_funct7b5}, {31'd0, v[i].f7});
         chk($sformatf("v%0d_illegal", i), {31'd0, ex_illegal}, {31'd0, v[i].ill});
      end
      if_instr = 32'h002081B3;
      if_pc = 32'h200;
      wb_regwrite = 1'b1;
      wb_write_reg = 5'd1;
      wb_write_data = 32'hDEADBEEF;
      edge_();
      chk("same_edge_rs1", ex_rs1_data, 32'hDEADBEEF);
      chk("same_edge_rs2", ex_rs2_data, 32'h10000002);
      ex_ready = 1'b0;
      if_instr = 32'h00500093;
      if_pc = 32'h300;
      wb_write_reg = 5'd2;
      wb_write_data = 32'h1234;
      #1;
      chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
      edge_();
      wb_regwrite = 1'b0;
      chk("stall1_rs2", ex_rs2_data, 32'h1234);
      chk("stall1_rs1", ex_rs1_data, 32'hDEADBEEF);
      for (int c = 2; c <= 3; c++) begin
         edge_();
         chk($sformatf("stall%0d_rs2", c), ex_rs2_data, 32'h1234);
         chk($sformatf("stall%0d_pc", c), ex_pc, 32'h200);
         chk($sformatf("stall%0d_rd", c), {27'd0, ex_rd}, 32'd3);
         chk($sformatf("stall%0d_valid", c), {31'd0, ex_valid}, 32'd1);
         chk($sformatf("stall%0d_id_ready", c), {31'd0, id_ready}, 32'd0);
      end
      flush = 1'b1;
      if_instr = 32'h123452B7;
      if_pc = 32'h400;
      #1;
      chk("flush_id_ready", {31'd0, id_ready}, 32'd1);
      edge_();
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_pc", ex_pc, 32'h200);
      flush = 1'b0;
      if_valid = 1'b0;
      ex_ready = 1'b1;
      edge_();
      chk("post_flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("post_flush_rd", {27'd0, ex_rd}, 32'd3);
      if_valid = 1'b1;
      if_instr = 32'h00500093;
      if_pc = 32'h500;
      ex_ready = 1'b0;
      wb_regwrite = 1'b1;
      wb_write_reg = 5'd0;
      wb_write_data = 32'hFFFFFFFF;
      edge_();
      chk("x0_valid", {31'd0, ex_valid}, 32'd1);
      chk("x0_rs1", ex_rs1_data, 32'd0);
      if_valid = 1'b0;
      wb_regwrite = 1'b0;
      edge_();
      chk("x0_hold_pc", ex_pc, 32'h500);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("async_rst_pc", ex_pc, 32'd0);
      chk("async_rst_rd", {27'd0, ex_rd}, 32'd0);
      edge_();
      RESET_N = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
